// File: rtl/ofifo_deskew_if.sv
// ---------------------------------------------------------------------------
// ofifo_deskew_if
//   Bundle of the data/handshake signals of the output de-skew FIFO.
//   master : the side that pushes lane results and pops aligned rows
//            (MAC array south edge + writeback controller)
//   slave  : the FIFO itself
// Signals
//   in        col*bw  lane j data at in[(j+1)*bw-1 : j*bw]
//   wr        col     per-lane write strobe
//   rd        1       pop one aligned row
//   out       col*bw  registered aligned row
//   o_full    1       some lane holds depth entries
//   o_ready   1       !o_full
//   o_valid   1       every lane holds at least one entry
//   o_overflow / o_underflow (only with OFIFO_ERR_EN) sticky error flags
// ---------------------------------------------------------------------------
interface ofifo_deskew_if #(
  parameter int col = 8,
  parameter int bw  = 16
);
  logic [col*bw-1:0] in;
  logic [col-1:0]    wr;
  logic              rd;
  logic [col*bw-1:0] out;
  logic              o_full;
  logic              o_ready;
  logic              o_valid;
`ifdef OFIFO_ERR_EN
  logic              o_overflow;
  logic              o_underflow;
`endif

  modport master (
    output in, wr, rd,
    input  out, o_full, o_ready, o_valid
`ifdef OFIFO_ERR_EN
    , input o_overflow, o_underflow
`endif
  );

  modport slave (
    input  in, wr, rd,
    output out, o_full, o_ready, o_valid
`ifdef OFIFO_ERR_EN
    , output o_overflow, o_underflow
`endif
  );
endinterface

// File: rtl/ofifo_deskew.sv
// ---------------------------------------------------------------------------
// ofifo_deskew
//   Output-side buffer of the systolic datapath. Each MAC column pushes into
//   its own lane whenever its strobe fires (results arrive skewed by one
//   cycle per column); a single rd pops one entry from every lane at once,
//   so the row leaves re-aligned.
// Ports
//   clk    clock, all state changes on posedge
//   reset  synchronous, active-high
//   fifo   ofifo_deskew_if.slave : in, wr, rd -> out, o_full, o_ready, o_valid
// Parameters
//   col    number of lanes            bw     bits per lane entry
//   depth  entries per lane (power of 2, >= 2)
// Configuration
//   OFIFO_ERR_EN  adds sticky o_overflow / o_underflow on the interface,
//                 cleared only by reset.
// ---------------------------------------------------------------------------
module ofifo_deskew #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic        clk,
  input  logic        reset,
  ofifo_deskew_if.slave fifo
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_cnt = (aw+1)'(depth);

  // Pointers carry one extra MSB so equal low bits can mean either empty or
  // full; the MSB tells the two apart.
  logic [aw:0]       wptr [col];
  logic [aw:0]       rptr;
  logic [aw:0]       cnt  [col];
  logic [bw-1:0]     mem  [col][depth];
  logic [col-1:0]    lane_full;
  logic [col-1:0]    lane_empty;
  logic [col-1:0]    wr_ok;
  logic              rd_ok;
  logic              valid;
  logic [col*bw-1:0] row;
  logic [col*bw-1:0] out_q;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    lane_full  = '0;
    lane_empty = '0;
    wr_ok      = '0;
    row        = '0;
    for (int j = 0; j < col; j++) begin
      cnt[j]        = wptr[j] - rptr;
      lane_full[j]  = (cnt[j] == depth_cnt);
      lane_empty[j] = (cnt[j] == '0);
      // A full lane drops its write even if this same edge pops it.
      wr_ok[j]      = fifo.wr[j] && !lane_full[j];
      row[j*bw +: bw] = mem[j][rptr[aw-1:0]];
    end
  end

  // o_valid uses pre-edge counts, so a lane's first entry can never be
  // popped on the same edge that writes it.
  assign valid = &(~lane_empty);
  assign rd_ok = fifo.rd && valid;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < col; j++) wptr[j] <= '0;
      rptr  <= '0;
      out_q <= '0;
    end else begin
      for (int j = 0; j < col; j++) begin
        if (wr_ok[j]) wptr[j] <= wptr[j] + 1'b1;
      end
      if (rd_ok) begin
        rptr  <= rptr + 1'b1;
        out_q <= row;
      end
    end
  end

  // NOTE: storage has no reset; clearing the pointers already discards every
  // buffered entry, and stale words are never read before being rewritten.
  always_ff @(posedge clk) begin
    for (int j = 0; j < col; j++) begin
      if (wr_ok[j]) mem[j][wptr[j][aw-1:0]] <= fifo.in[j*bw +: bw];
    end
  end

  assign fifo.out     = out_q;
  assign fifo.o_full  = |lane_full;
  assign fifo.o_ready = ~(|lane_full);
  assign fifo.o_valid = valid;

`ifdef OFIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (|(fifo.wr & lane_full)) overflow_q  <= 1'b1;
      if (fifo.rd && !valid)      underflow_q <= 1'b1;
    end
  end

  assign fifo.o_overflow  = overflow_q;
  assign fifo.o_underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ofifo_deskew.sv
// ---------------------------------------------------------------------------
// tb_ofifo_deskew
//   Self-checking bench for ofifo_deskew (col=8, bw=16, depth=64). A
//   reference model of per-lane queues predicts out and the flags each cycle.
// ---------------------------------------------------------------------------
module tb_ofifo_deskew;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;

  ofifo_deskew_if #(.col(COL), .bw(BW)) bus ();

  ofifo_deskew #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per lane plus the registered output row.
  logic [BW-1:0]      mq [COL][$];
  logic [COL*BW-1:0]  m_out;
  logic               m_ovf;
  logic               m_unf;
  int                 pops;

  function automatic bit model_valid();
    for (int j = 0; j < COL; j++) if (mq[j].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_full();
    for (int j = 0; j < COL; j++) if (mq[j].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},     128'(bus.out),     128'(m_out));
    check({tag, ".o_valid"}, 128'(bus.o_valid), 128'(model_valid()));
    check({tag, ".o_full"},  128'(bus.o_full),  128'(model_full()));
    check({tag, ".o_ready"}, 128'(bus.o_ready), 128'(!model_full()));
`ifdef OFIFO_ERR_EN
    check({tag, ".o_overflow"},  128'(bus.o_overflow),  128'(m_ovf));
    check({tag, ".o_underflow"}, 128'(bus.o_underflow), 128'(m_unf));
`endif
  endtask

  // Apply the current inputs across one rising edge, advance the model,
  // then compare on the following falling edge.
  task automatic step(input string tag);
    bit [COL-1:0] full_pre;
    bit           valid_pre;
    valid_pre = model_valid();
    for (int j = 0; j < COL; j++) full_pre[j] = (mq[j].size() == DEPTH);
    @(posedge clk);
    if (reset) begin
      for (int j = 0; j < COL; j++) mq[j].delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (bus.rd && valid_pre) begin
        for (int j = 0; j < COL; j++) m_out[j*BW +: BW] = mq[j].pop_front();
        pops++;
      end
      if (bus.rd && !valid_pre) m_unf = 1'b1;
      for (int j = 0; j < COL; j++) begin
        if (bus.wr[j] && full_pre[j]) m_ovf = 1'b1;
        if (bus.wr[j] && !full_pre[j]) mq[j].push_back(bus.in[j*BW +: BW]);
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic rand_in();
    for (int j = 0; j < COL; j++) bus.in[j*BW +: BW] = BW'($urandom);
  endtask

  initial begin
    int cyc;
    m_out = '0; m_ovf = 1'b0; m_unf = 1'b0; pops = 0;
    reset = 1'b1; bus.in = '0; bus.wr = '0; bus.rd = 1'b0;
    @(negedge clk);

    // 1. Reset, then idle.
    step("reset");
    reset = 1'b0;
    step("idle");
    step("idle2");

    // 2. Skewed fill: lane j written at cycle j, then one aligned pop.
    for (int j = 0; j < COL; j++) begin
      rand_in();
      bus.in[j*BW +: BW] = 16'h0100 + 16'(j);
      bus.wr = COL'(1) << j;
      step("skew_fill");
    end
    bus.wr = '0;
    bus.rd = 1'b1;
    step("skew_pop");
    bus.rd = 1'b0;
    step("skew_hold");

    // 3. Lane 0 to full, overflow attempt, fill others, drain 64 rows.
    for (int i = 0; i < DEPTH; i++) begin
      bus.in = '0;
      bus.in[BW-1:0] = BW'(i);
      bus.wr = COL'(1);
      step("lane0_fill");
    end
    bus.in[BW-1:0] = 16'hdead;
    step("lane0_overflow");
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < COL; j++) bus.in[j*BW +: BW] = BW'(i);
      bus.in[BW-1:0] = 16'hbeef;
      bus.wr = '1;
      step("others_fill");
    end
    bus.wr = '0;
    bus.rd = 1'b1;
    for (int i = 0; i < DEPTH; i++) step("drain");
    // 5. Pop on an empty FIFO: out holds, underflow flagged.
    step("underflow");
    bus.rd = 1'b0;
    step("underflow_hold");

    // 4. Continuous stream of 200 rows across pointer wraps.
    pops = 0;
    cyc  = 0;
    bus.wr = '1;
    while (pops < 200 && cyc < 1000) begin
      rand_in();
      bus.rd = model_valid();
      step("stream");
      cyc++;
    end
    check("stream_rows", 128'(pops), 128'(200));
    bus.wr = '0;
    bus.rd = model_valid();
    step("stream_tail");
    bus.rd = 1'b0;

    // Random lane subsets and random pops, reaching full lanes at times.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      bus.wr = COL'($urandom);
      bus.rd = ($urandom_range(0, 3) == 0);
      step("random");
    end

    // 6. Reset with 10 rows buffered, then restart from entry 0.
    reset = 1'b1; bus.wr = '0; bus.rd = 1'b0;
    step("pre_reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_in();
      bus.wr = '1;
      step("buffer10");
    end
    bus.wr = '0;
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      bus.wr = '1;
      step("refill");
    end
    bus.wr = '0;
    bus.rd = 1'b1;
    for (int i = 0; i < 4; i++) step("refill_pop");
    bus.rd = 1'b0;
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
